// File: rtl/msu_sd_arbiter.sv
// Shares the single HPS sector-read channel between the MSU audio and data streamers.
// Audio wins contention while its FIFO is low; otherwise the two sides alternate.
//
// state  | meaning
// DRAIN  | after reset, wait for the HPS to drop a leftover hps_ack
// IDLE   | no grant held, arbitrating pending requests
// ISSUE  | hps_rd asserted, waiting for hps_ack (watchdog running)
// XFER   | hps_ack high, steering buffer strobes to the granted side
module msu_sd_arbiter #(
  parameter int unsigned URGENT_LEVEL = 512,
  parameter int unsigned ACK_TIMEOUT  = 24'hFF_FFFF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        audio_req,
  input  logic [20:0] audio_lba,
  input  logic [11:0] audio_fifo_usedw,
  input  logic        data_req,
  input  logic [20:0] data_lba,
  input  logic        hps_ack,
  input  logic        hps_buff_wr,
  output logic        hps_rd,
  output logic [20:0] hps_lba,
  output logic        audio_ack,
  output logic        data_ack,
  output logic        audio_buff_wr,
  output logic        data_buff_wr,
  output logic [1:0]  grant,
  output logic [8:0]  xfer_words,
  output logic        timeout_err
);

  typedef enum logic [1:0] {
    S_DRAIN = 2'd0,
    S_IDLE  = 2'd1,
    S_ISSUE = 2'd2,
    S_XFER  = 2'd3
  } state_t;

  // Down-counter loaded on grant; abandon when it has counted to zero,
  // which lands exactly ACK_TIMEOUT cycles after ISSUE entry.
  localparam logic [23:0] WDOG_LOAD = 24'(ACK_TIMEOUT - 1);
  localparam logic [8:0]  XFER_MAX  = 9'd256;

  state_t      state_q, state_d;
  logic        hps_rd_q, hps_rd_d;
  logic [20:0] hps_lba_q, hps_lba_d;
  logic [1:0]  grant_q, grant_d;
  logic [8:0]  xfer_words_q, xfer_words_d;
  logic        timeout_err_q, timeout_err_d;
  logic        last_data_q, last_data_d;
  logic [23:0] wdog_q, wdog_d;

  logic audio_urgent;
  logic pick_audio;
  logic any_req;
  logic wdog_tc;
  logic count_wr;

  assign audio_urgent = ({20'd0, audio_fifo_usedw} < 32'(URGENT_LEVEL));
  assign any_req      = audio_req | data_req;
  assign pick_audio   = audio_req & (~data_req | audio_urgent | last_data_q);
  assign wdog_tc      = (wdog_q == 24'd0);
  assign count_wr     = hps_buff_wr & (xfer_words_q != XFER_MAX);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= S_DRAIN;
      hps_rd_q      <= 1'b0;
      hps_lba_q     <= 21'd0;
      grant_q       <= 2'b00;
      xfer_words_q  <= 9'd0;
      timeout_err_q <= 1'b0;
      last_data_q   <= 1'b1;
      wdog_q        <= 24'd0;
    end else begin
      state_q       <= state_d;
      hps_rd_q      <= hps_rd_d;
      hps_lba_q     <= hps_lba_d;
      grant_q       <= grant_d;
      xfer_words_q  <= xfer_words_d;
      timeout_err_q <= timeout_err_d;
      last_data_q   <= last_data_d;
      wdog_q        <= wdog_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_DRAIN: if (!hps_ack) state_d = S_IDLE;
      S_IDLE:  if (any_req) state_d = S_ISSUE;
      S_ISSUE: begin
        if (hps_ack)      state_d = S_XFER;
        else if (wdog_tc) state_d = S_IDLE;
      end
      S_XFER:  if (!hps_ack) state_d = S_IDLE;
      default: state_d = S_DRAIN;
    endcase
  end

  always_comb begin
    hps_rd_d      = hps_rd_q;
    hps_lba_d     = hps_lba_q;
    grant_d       = grant_q;
    xfer_words_d  = xfer_words_q;
    timeout_err_d = 1'b0;
    last_data_d   = last_data_q;
    wdog_d        = wdog_q;
    case (state_q)
      S_DRAIN: begin
        hps_rd_d = 1'b0;
        grant_d  = 2'b00;
      end
      S_IDLE: begin
        if (any_req) begin
          hps_rd_d     = 1'b1;
          hps_lba_d    = pick_audio ? audio_lba : data_lba;
          grant_d      = pick_audio ? 2'b01 : 2'b10;
          last_data_d  = ~pick_audio;
          wdog_d       = WDOG_LOAD;
          xfer_words_d = 9'd0;
        end
      end
      S_ISSUE: begin
        if (hps_ack) begin
          hps_rd_d = 1'b0;
          if (count_wr) xfer_words_d = xfer_words_q + 9'd1;
        end else if (wdog_tc) begin
          // last_grant stays on the abandoned side so the other side wins next.
          hps_rd_d      = 1'b0;
          grant_d       = 2'b00;
          timeout_err_d = 1'b1;
        end else begin
          wdog_d = wdog_q - 24'd1;
        end
      end
      S_XFER: begin
        if (count_wr) xfer_words_d = xfer_words_q + 9'd1;
        if (!hps_ack) grant_d = 2'b00;
      end
      default: begin
        hps_rd_d = 1'b0;
        grant_d  = 2'b00;
      end
    endcase
  end

  assign hps_rd        = hps_rd_q;
  assign hps_lba       = hps_lba_q;
  assign grant         = grant_q;
  assign xfer_words    = xfer_words_q;
  assign timeout_err   = timeout_err_q;
  assign audio_ack     = hps_ack & grant_q[0];
  assign data_ack      = hps_ack & grant_q[1];
  assign audio_buff_wr = hps_buff_wr & grant_q[0];
  assign data_buff_wr  = hps_buff_wr & grant_q[1];

endmodule

// File: doc/msu_sd_arbiter.md
# msu_sd_arbiter

Arbitrates the single HPS sector-read channel between the MSU audio streamer and the MSU data streamer. It accepts level-held sector requests with their LBAs, grants one requester at a time, drives the shared HPS request/LBA, and steers ack and buffer-write strobes back to the granted side only. Audio takes priority when its playback FIFO is running low; otherwise the two requesters alternate round-robin. A watchdog abandons requests the HPS never acknowledges.

## Interface
Parameters:
- URGENT_LEVEL, 512: audio FIFO fill (words) below which audio wins every contention.
- ACK_TIMEOUT, 2^24-1: cycles in ISSUE without hps_ack before abandoning; 24-bit counter.

Ports (reset synchronous, active-high; clock clk):
- clk  in  1  system clock
- reset  in  1  synchronous active-high reset
- audio_req  in  1  audio sector request, held until audio_ack seen
- audio_lba  in  21  audio sector address
- audio_fifo_usedw  in  12  audio FIFO fill level
- data_req  in  1  data sector request, held until data_ack seen
- data_lba  in  21  data sector address
- hps_ack  in  1  HPS transfer-active
- hps_buff_wr  in  1  HPS buffer word strobe
- hps_rd  out  1  shared request to HPS
- hps_lba  out  21  latched LBA of granted request
- audio_ack / data_ack  out  1 each  hps_ack gated by grant
- audio_buff_wr / data_buff_wr  out  1 each  hps_buff_wr gated by grant
- grant  out  2  one-hot {data,audio}; 0 when idle
- xfer_words  out  9  words strobed in current/last transfer
- timeout_err  out  1  one-cycle pulse on watchdog expiry

## Operation
- States: DRAIN, IDLE, ISSUE, XFER.
- DRAIN (entered from reset): stay while hps_ack=1; go IDLE when hps_ack=0. No grants issued.
- IDLE: no request -> stay. Single request -> grant it. Both: audio if audio_fifo_usedw < URGENT_LEVEL, else the side not equal to last_grant. On grant: latch lba to hps_lba, set grant, hps_rd<=1, clear watchdog and xfer_words, update last_grant, go ISSUE.
- ISSUE: hps_ack=1 -> hps_rd<=0, go XFER. Watchdog reaches ACK_TIMEOUT -> hps_rd<=0, grant<=0, timeout_err pulse, last_grant kept as the abandoned side (so the other side wins next contention), go IDLE.
- XFER: each hps_buff_wr increments xfer_words (saturate at 256). hps_ack falls -> grant<=0, go IDLE.
- Steering is combinational from registered grant: audio_ack = hps_ack & grant[0], etc. Ungranted side sees 0 always; hps_ack with grant=0 is ignored.
- Requests are not re-sampled during ISSUE/XFER; a requester deasserting its request mid-transfer does not abort it.
- Comparison audio_fifo_usedw < URGENT_LEVEL is unsigned 12-bit.

## Timing
- Reset values: hps_rd=0, hps_lba=0, grant=0, xfer_words=0, timeout_err=0, last_grant=data (so audio wins the first tie), state DRAIN.
- Grant latency: request high in IDLE cycle N -> hps_rd, hps_lba, grant valid at N+1.
- hps_rd falls the cycle after hps_ack is first sampled high (one-cycle overlap allowed).
- Ack fall to next grant: ack low sampled at M -> IDLE at M+1 -> next hps_rd at M+2. Minimum two-cycle gap between transfers.
- Reset mid-XFER: outputs to reset values next cycle; remaining hps_buff_wr strobes not steered; DRAIN holds off new grants until hps_ack low.
- Watchdog: abandon occurs exactly ACK_TIMEOUT cycles after entering ISSUE.

## Test plan
- Single audio request lba=5 -> hps_rd=1, hps_lba=5, grant=01 next cycle; HPS acks, 256 wr -> audio_buff_wr 256 pulses, data_buff_wr 0, xfer_words=256, grant=0 after ack fall.
- Both requests held, usedw=1500 -> grants alternate audio, data, audio, data across four sectors.
- Both requests held, usedw=100 -> audio granted on every contention; data served only once audio_req drops.
- No ack with ACK_TIMEOUT=16 -> hps_rd drops 16 cycles after ISSUE entry, timeout_err one pulse, with data_req also high next grant is data.
- Reset after 100 of 256 words with hps_ack still high -> grant=0, remaining strobes unsteered, no hps_rd until hps_ack low, then pending request granted.
- Stray hps_ack/hps_buff_wr while idle -> no ack or buff_wr on either side, xfer_words unchanged.
